// File: rtl/memc_deskew_pkg.sv
// Shared types and default sizing for the systolic-array result de-skew block.
package memc_deskew_pkg;

    localparam int BITS_C_DEF = 24;
    localparam int DIM_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/deskew_lane.sv
// One lane of the de-skew network: STAGES-deep delay line that shifts only on en.
module deskew_lane #(
    parameter int BITS   = 24,
    parameter int STAGES = 0
) (
    input  logic            clk,
    input  logic            en,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_pass
            assign dout = din;
        end else begin : g_delay
            logic [BITS-1:0] sr [STAGES];

            // NOTE: pure data storage, so no reset; valid-ness is tracked by the control path.
            always_ff @(posedge clk) begin
                if (en) begin
                    sr[0] <= din;
                    for (int s = 1; s < STAGES; s++) begin
                        sr[s] <= sr[s-1];
                    end
                end
            end

            assign dout = sr[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/memc_deskew.sv
// Collects a skewed DIM x DIM result matrix, realigns it into rows and streams the
// rows out in order through a DIM-entry FIFO with a valid/ready handshake.
module memc_deskew
    import memc_deskew_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEF,
    parameter int DIM    = DIM_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 en,
    input  logic signed [DIM-1:0][BITS_C-1:0]    Cin,
    output logic signed [DIM-1:0][BITS_C-1:0]    Cout,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(DIM)-1:0]               out_row,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ROW_W = $clog2(DIM);
    localparam int T_W   = $clog2(2*DIM-1);
    localparam int CNT_W = $clog2(DIM+1);

    localparam logic [T_W-1:0]   T_ROW0   = T_W'(DIM-1);
    localparam logic [T_W-1:0]   T_LAST   = T_W'(2*DIM-2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM-1);

    typedef logic [DIM-1:0][BITS_C-1:0] row_t;

    function automatic logic [ROW_W-1:0] next_idx(input logic [ROW_W-1:0] p);
        return (p == ROW_LAST) ? '0 : p + 1'b1;
    endfunction

    state_t            state, state_nx;
    logic [T_W-1:0]    t;
    logic              beat;
    row_t              aligned;

    logic              wr_pending;
    row_t              wr_row;
    row_t              mem [DIM];
    logic [ROW_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    // Beats only count while collecting; en elsewhere must not disturb the lanes.
    assign beat = en && (state == COLLECT);

    generate
        for (genvar i = 0; i < DIM; i++) begin : g_lane
            deskew_lane #(
                .BITS   (BITS_C),
                .STAGES (DIM-1-i)
            ) u_lane (
                .clk  (clk),
                .en   (beat),
                .din  (Cin[i]),
                .dout (aligned[i])
            );
        end
    endgenerate

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nx = COLLECT;
            COLLECT: if (beat && (t == T_LAST)) state_nx = DRAIN;
            DRAIN: begin
                if ((count == '0) && !wr_pending) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign push = wr_pending;
    assign pop  = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            wr_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_row    <= '0;
        end else begin
            state <= state_nx;

            if ((state == IDLE) && start) begin
                t <= '0;
            end else if (beat) begin
                t <= t + 1'b1;
            end

            // The aligned row is staged one cycle before it lands in the FIFO.
            wr_pending <= beat && (t >= T_ROW0);

            if (push) wr_ptr <= next_idx(wr_ptr);
            if (pop) begin
                rd_ptr  <= next_idx(rd_ptr);
                out_row <= next_idx(out_row);
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat) wr_row <= aligned;
        if (push) mem[wr_ptr] <= wr_row;
    end

    assign out_valid = (count != '0);
    assign Cout      = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_row == ROW_LAST);

endmodule

// File: doc/memc_deskew.md
MEMC_DESKEW -- requirements
Module: memc_deskew

Interface
REQ-001 The block SHALL have parameter BITS_C, default 24, giving the signed width of one result element.
REQ-002 The block SHALL have parameter DIM, default 8, giving the systolic array dimension (lanes and rows per matrix).
REQ-003 Port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: begins collection of one DIM x DIM result matrix.
REQ-006 Port en, input, 1 bit: skewed input beat valid; the internal beat counter and delay lines advance only when en=1.
REQ-007 Port Cin, input, DIM x BITS_C signed: skewed array outputs, lane i.
REQ-008 Port Cout, output, DIM x BITS_C signed: one de-skewed, row-aligned result row.
REQ-009 Port out_valid, output, 1 bit: Cout holds a valid row.
REQ-010 Port out_ready, input, 1 bit: consumer accepts Cout.
REQ-011 Port out_row, output, clog2(DIM) bits: index of the row on Cout.
REQ-012 Port out_last, output, 1 bit: the row on Cout is row DIM-1.
REQ-013 Port busy, output, 1 bit: state is not IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when the last row has been accepted.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT and DRAIN.
- IDLE to COLLECT on start=1.
- COLLECT to DRAIN on the en beat with t=2*DIM-2.
- DRAIN to IDLE when the row FIFO is empty; done=1 in that same cycle.
REQ-016 start SHALL be ignored outside IDLE; en SHALL be ignored in IDLE and DRAIN.
REQ-017 In COLLECT, beat counter t SHALL count en beats from 0 to 2*DIM-2; beat t carries element row (t-i) on lane i when 0 <= t-i < DIM, and don't-care otherwise.
REQ-018 Lane i SHALL pass through a delay line of DIM-1-i stages. Each stage shifts only on en beats; lane DIM-1 has zero stages.
REQ-019 On an en beat with t >= DIM-1, aligned row r = t-(DIM-1) SHALL be written into the row FIFO (depth DIM). Lane i's contribution is its delayed value.
REQ-020 out_valid SHALL rise the cycle after row 0 is written, giving a latency of DIM beats plus 1 cycle from the first en beat.
REQ-021 A row SHALL transfer when out_valid && out_ready. Rows SHALL leave in order 0..DIM-1, with out_row counting and out_last=1 only on row DIM-1.
REQ-022 While out_valid=1 and out_ready=0, Cout, out_row and out_last SHALL hold stable.
REQ-023 A FIFO write and a FIFO read in the same cycle SHALL both take effect. The FIFO cannot overflow, because exactly DIM rows are written per matrix and a new start is accepted only in IDLE.
REQ-024 Draining SHALL be allowed during COLLECT; out_valid is independent of state whenever the FIFO is non-empty.
REQ-025 Element values SHALL pass bit-exact, with no arithmetic, truncation or sign change.
REQ-026 A start in the same cycle as done SHALL be ignored; the new start is accepted from the following cycle in IDLE.

Reset
REQ-027 rst=1 at any clock edge SHALL force state IDLE and clear t, the row FIFO pointers, the count and the out_row counter.
REQ-028 After reset, out_valid=0, out_last=0, out_row=0, busy=0 and done=0; Cout SHALL read 0.
REQ-029 Reset mid-COLLECT or mid-DRAIN SHALL discard all partial rows with no done pulse. Delay-line contents need not be cleared.

Structure
REQ-030 A shared package SHALL hold the state enum and the default values of BITS_C and DIM.
REQ-031 The per-lane delay line SHALL be a sub-module deskew_lane, with parameters BITS and STAGES, en-gated. STAGES=0 SHALL be a pass-through.
REQ-032 The row FIFO SHALL be implemented inside memc_deskew as a DIM-entry register array with a count.

Verification (DIM=4, BITS_C=24)
REQ-033 Directed scenario, basic: start, then 7 consecutive en beats carrying a skewed 4x4 matrix with C[r][c]=16*r+c, out_ready=1. Required response: rows {0,1,2,3}, {16..19}, {32..35}, {48..51} in order; first out_valid 5 cycles after the first en; done exactly once; busy=0 after done.
REQ-034 Directed scenario, en gaps: the same matrix with en low for 2 cycles between every beat. Required response: identical row contents and order; no row written on non-en cycles.
REQ-035 Directed scenario, backpressure: out_ready=0 until all 7 beats are done, then 1. Required response: 4 rows held in the FIFO; Cout stable while stalled; done after the 4th accept.
REQ-036 Directed scenario, signed extremes: elements -8388608 and 8388607 on all lanes. Required response: Cout bit-exact.
REQ-037 Directed scenario, reset mid-operation: rst asserted at beat t=4. Required response: next cycle out_valid=0, busy=0, no done pulse; a following full matrix is collected correctly.
REQ-038 Directed scenario, protocol misuse: start pulsed during COLLECT, and en pulsed in IDLE. Required response: both ignored; output identical to the basic scenario.
